// File: rtl/inert_intf_ctrl.sv
// Inertial sensor sequencer: settle, configure over SPI, then read pitch rate and Z accel on each INT.
// Defining INERT_TIMEOUT_EN builds a done-watchdog that drives the sticky err flag.
module inert_intf_ctrl #(
    parameter int INIT_WAIT_BITS = 16,
    parameter int TIMEOUT_BITS   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld,
    output logic        err
);
    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_CFG    = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_RD     = 2'd3;

    localparam logic [INIT_WAIT_BITS-1:0] SETTLE_END = '1;

    logic [1:0]                state_reg;
    logic [INIT_WAIT_BITS-1:0] timer_reg;
    logic [1:0]                idx_reg;
    logic                      busy_reg;
    logic                      pending_reg;
    logic                      wrt_reg;
    logic                      vld_reg;
    logic [15:0]               cmd_reg;
    logic [15:0]               ptch_rt_reg;
    logic [15:0]               az_reg;
    logic [7:0]                ptch_lo_reg;
    logic [7:0]                ptch_hi_reg;
    logic [7:0]                az_lo_reg;
    logic [2:0]                int_sync_reg;
    logic                      int_edge_reg;
    logic                      done_ok;
    logic                      is_rd;
    logic                      timeout_hit;
    logic                      unused_ok;

    function automatic logic [15:0] xfer_cmd(input logic rd, input logic [1:0] idx);
        logic [15:0] c;
        if (rd) begin
            case (idx)
                2'd0:    c = 16'hA200;
                2'd1:    c = 16'hA300;
                2'd2:    c = 16'hAC00;
                default: c = 16'hAD00;
            endcase
        end else begin
            case (idx)
                2'd0:    c = 16'h0D02;
                2'd1:    c = 16'h1053;
                2'd2:    c = 16'h1150;
                default: c = 16'h1460;
            endcase
        end
        return c;
    endfunction

    // Two synchroniser stages plus a history stage for edge detection.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_int_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) int_sync_reg[gi] <= 1'b0;
                    else     int_sync_reg[gi] <= INT;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) int_sync_reg[gi] <= 1'b0;
                    else     int_sync_reg[gi] <= int_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) int_edge_reg <= 1'b0;
        else     int_edge_reg <= int_sync_reg[1] & ~int_sync_reg[2];
    end

    // A done coincident with wrt belongs to no transaction yet.
    assign done_ok = busy_reg & ~wrt_reg & done;
    assign is_rd   = (state_reg == ST_RD);

`ifdef INERT_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] wd_reg;
    logic                    err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_reg  <= '0;
            err_reg <= 1'b0;
        end else begin
            if (!busy_reg || wrt_reg) wd_reg <= '0;
            else                      wd_reg <= wd_reg + 1'b1;
            if (timeout_hit)          err_reg <= 1'b1;
        end
    end

    assign timeout_hit = busy_reg && !wrt_reg && !done && (wd_reg == '1);
    assign err         = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_SETTLE;
            timer_reg   <= '0;
            idx_reg     <= 2'd0;
            busy_reg    <= 1'b0;
            pending_reg <= 1'b0;
            wrt_reg     <= 1'b0;
            vld_reg     <= 1'b0;
            cmd_reg     <= 16'h0000;
            ptch_rt_reg <= 16'h0000;
            az_reg      <= 16'h0000;
            ptch_lo_reg <= 8'h00;
            ptch_hi_reg <= 8'h00;
            az_lo_reg   <= 8'h00;
        end else begin
            wrt_reg <= 1'b0;
            vld_reg <= 1'b0;
            if (int_edge_reg && is_rd) pending_reg <= 1'b1;
            case (state_reg)
                ST_SETTLE: begin
                    timer_reg <= timer_reg + 1'b1;
                    if (timer_reg == SETTLE_END) state_reg <= ST_CFG;
                end
                ST_IDLE: begin
                    if (int_edge_reg || pending_reg) begin
                        pending_reg <= 1'b0;
                        state_reg   <= ST_RD;
                    end
                end
                default: begin
                    if (!busy_reg) begin
                        wrt_reg  <= 1'b1;
                        busy_reg <= 1'b1;
                        cmd_reg  <= xfer_cmd(is_rd, idx_reg);
                    end else if (done_ok) begin
                        if (is_rd) begin
                            case (idx_reg)
                                2'd0: ptch_lo_reg <= rd_data[7:0];
                                2'd1: ptch_hi_reg <= rd_data[7:0];
                                2'd2: az_lo_reg   <= rd_data[7:0];
                                default: begin
                                    // Both words commit together so no half-updated value is seen.
                                    ptch_rt_reg <= {ptch_hi_reg, ptch_lo_reg};
                                    az_reg      <= {rd_data[7:0], az_lo_reg};
                                    vld_reg     <= 1'b1;
                                end
                            endcase
                        end
                        if (idx_reg == 2'd3) begin
                            busy_reg  <= 1'b0;
                            idx_reg   <= 2'd0;
                            state_reg <= ST_IDLE;
                        end else begin
                            idx_reg <= idx_reg + 2'd1;
                            wrt_reg <= 1'b1;
                            cmd_reg <= xfer_cmd(is_rd, idx_reg + 2'd1);
                        end
                    end else if (timeout_hit) begin
                        // Abandoned config restarts from its first write; abandoned read drops to idle.
                        busy_reg <= 1'b0;
                        idx_reg  <= 2'd0;
                        if (is_rd) state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign unused_ok = ^{rd_data[15:8], (TIMEOUT_BITS > 0)};

    assign wrt     = wrt_reg;
    assign cmd     = cmd_reg;
    assign ptch_rt = ptch_rt_reg;
    assign AZ      = az_reg;
    assign vld     = vld_reg;
endmodule

// File: tb/tb_inert_intf_ctrl.sv
// Bench for inert_intf_ctrl: SPI engine model with response queue, output hold monitor, directed steps.
`timescale 1ns/1ps
module tb_inert_intf_ctrl;
    localparam int IWB        = 6;
    localparam int SETTLE_CYC = (1 << IWB) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt, vld, err;
    logic [15:0] cmd, ptch_rt, AZ;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        rst_q = 1'b1;
    bit          mon_en = 1'b0;
    int          eng_lat = 5;
    logic        hold_en = 1'b0;
    logic [15:0] hold_cmd = 16'h0000;
    logic [15:0] held_p = 16'h0000;
    logic [15:0] held_a = 16'h0000;
    logic [15:0] cmd_log[$];
    int          wrt_cyc[$];
    logic [7:0]  rsp_q[$];
    logic [15:0] vld_p[$];
    logic [15:0] vld_a[$];
    int          vld_cyc[$];
    logic [15:0] cfg_cmds[4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    logic [15:0] rd_cmds[4]  = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

    inert_intf_ctrl #(.INIT_WAIT_BITS(IWB), .TIMEOUT_BITS(4)) dut (
        .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (cmd_log.size() < n && k < budget) begin tick(1); k++; end
        chk({tag, "_reached"}, 32'(cmd_log.size() >= n), 32'd1);
    endtask

    // SPI engine: done arrives eng_lat cycles after wrt; read commands take their low byte from rsp_q.
    initial begin : engine
        logic [15:0] c;
        @(posedge clk); #1;
        forever begin
            if (wrt === 1'b1) begin
                c = cmd;
                cmd_log.push_back(c);
                wrt_cyc.push_back(cyc);
                if (hold_en && c == hold_cmd) begin
                    @(posedge clk); #1;
                end else begin
                    repeat (eng_lat) @(posedge clk);
                    #1;
                    rd_data[15:8] = 8'($urandom);
                    if (c[15:8] inside {8'hA2, 8'hA3, 8'hAC, 8'hAD} && rsp_q.size() > 0)
                        rd_data[7:0] = rsp_q.pop_front();
                    else
                        rd_data[7:0] = 8'($urandom);
                    done = 1'b1;
                    @(posedge clk); #1;
                    done = 1'b0;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // Outputs may only move on a vld cycle; reset returns them to zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (vld === 1'b1) begin
                vld_p.push_back(ptch_rt);
                vld_a.push_back(AZ);
                vld_cyc.push_back(cyc);
                held_p = ptch_rt;
                held_a = AZ;
            end else begin
                if (rst_q) begin held_p = 16'h0000; held_a = 16'h0000; end
                chk("hold_ptch", 32'(ptch_rt), 32'(held_p));
                chk("hold_az", 32'(AZ), 32'(held_a));
            end
        end
    end

    task automatic do_read(input logic [7:0] b0, b1, b2, b3, input logic exp_err, input string tag);
        int base, nv, k;
        base = cmd_log.size();
        nv   = vld_p.size();
        rsp_q.push_back(b0); rsp_q.push_back(b1); rsp_q.push_back(b2); rsp_q.push_back(b3);
        INT = 1'b1; tick(2); INT = 1'b0;
        k = 0;
        while (vld_p.size() == nv && k < 400) begin tick(1); k++; end
        chk({tag, "_vld_cnt"}, 32'(vld_p.size()), 32'(nv + 1));
        if (vld_p.size() > nv && cmd_log.size() >= base + 4) begin
            chk({tag, "_ptch"}, 32'(vld_p[nv]), 32'({b1, b0}));
            chk({tag, "_az"}, 32'(vld_a[nv]), 32'({b3, b2}));
            for (int i = 0; i < 4; i++)
                chk({tag, "_cmd"}, 32'(cmd_log[base + i]), 32'(rd_cmds[i]));
            chk({tag, "_lat"}, 32'(vld_cyc[nv] - wrt_cyc[base]), 32'(4 * (eng_lat + 1)));
        end
        tick(5);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin : main
        int k, base, base2, nv;
        logic [7:0] b[8];

        rst = 1'b1;
        tick(2);
        chk("rst_wrt", 32'(wrt), 32'd0);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_ptch", 32'(ptch_rt), 32'd0);
        chk("rst_az", 32'(AZ), 32'd0);
        mon_en = 1'b1;
        rst = 1'b0;

        // Settle, then configuration with an INT toggled during the 2nd write.
        k = 0;
        while (wrt !== 1'b1 && k < 300) begin tick(1); k++; end
        chk("settle_min", 32'(k >= SETTLE_CYC), 32'd1);
        chk("settle_max", 32'(k <= SETTLE_CYC + 4), 32'd1);
        wait_log(2, 100, "cfg_w2");
        INT = 1'b1; tick(3); INT = 1'b0;
        wait_log(4, 200, "cfg_w4");
        tick(40);
        for (int i = 0; i < 4; i++)
            if (cmd_log.size() > i) chk("cfg_cmd", 32'(cmd_log[i]), 32'(cfg_cmds[i]));
        chk("cfg_no_rd", 32'(cmd_log.size()), 32'd4);
        chk("cfg_no_vld", 32'(vld_p.size()), 32'd0);

        do_read(8'h34, 8'h12, 8'h78, 8'hF6, 1'b0, "rd_fixed");
        for (int it = 0; it < 4; it++) begin
            eng_lat = $urandom_range(1, 6);
            do_read(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, "rd_rand");
        end

        // Two INT edges during the 2nd read collapse into one extra sequence.
        eng_lat = 15;
        base = cmd_log.size();
        nv   = vld_p.size();
        for (int i = 0; i < 8; i++) begin b[i] = 8'($urandom); rsp_q.push_back(b[i]); end
        INT = 1'b1; tick(2); INT = 1'b0;
        wait_log(base + 2, 200, "pend_w2");
        INT = 1'b1; tick(2); INT = 1'b0; tick(2); INT = 1'b1; tick(2); INT = 1'b0;
        k = 0;
        while (vld_p.size() < nv + 2 && k < 800) begin tick(1); k++; end
        tick(100);
        chk("pend_vld_cnt", 32'(vld_p.size()), 32'(nv + 2));
        chk("pend_cmd_cnt", 32'(cmd_log.size()), 32'(base + 8));
        if (vld_p.size() >= nv + 2) begin
            chk("pend_ptch0", 32'(vld_p[nv]), 32'({b[1], b[0]}));
            chk("pend_az0", 32'(vld_a[nv]), 32'({b[3], b[2]}));
            chk("pend_ptch1", 32'(vld_p[nv + 1]), 32'({b[5], b[4]}));
            chk("pend_az1", 32'(vld_a[nv + 1]), 32'({b[7], b[6]}));
        end

        // Reset while the 3rd read waits; its done lands after reset.
        eng_lat = 8;
        base = cmd_log.size();
        nv   = vld_p.size();
        for (int i = 0; i < 4; i++) rsp_q.push_back(8'($urandom));
        INT = 1'b1; tick(2); INT = 1'b0;
        wait_log(base + 3, 200, "rm_w3");
        tick(2);
        rst = 1'b1; tick(2); rst = 1'b0;
        chk("rm_ptch", 32'(ptch_rt), 32'd0);
        chk("rm_az", 32'(AZ), 32'd0);
        base2 = cmd_log.size();
        k = 0;
        while (wrt !== 1'b1 && k < 300) begin tick(1); k++; end
        chk("rm_settle", 32'(k >= SETTLE_CYC), 32'd1);
        chk("rm_no_vld", 32'(vld_p.size()), 32'(nv));
        wait_log(base2 + 4, 200, "rm_cfg");
        if (cmd_log.size() > base2) chk("rm_cfg_first", 32'(cmd_log[base2]), 32'h0D02);
        tick(40);
        rsp_q.delete();
        eng_lat = 3;
        do_read(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, "rm_rd");

`ifdef INERT_TIMEOUT_EN
        // Withheld done on the 2nd read: err sets, no vld, next INT reads normally.
        hold_cmd = 16'hA300;
        hold_en  = 1'b1;
        nv = vld_p.size();
        for (int i = 0; i < 4; i++) rsp_q.push_back(8'($urandom));
        INT = 1'b1; tick(2); INT = 1'b0;
        k = 0;
        while (err !== 1'b1 && k < 100) begin tick(1); k++; end
        chk("to_err", 32'(err), 32'd1);
        tick(10);
        chk("to_no_vld", 32'(vld_p.size()), 32'(nv));
        hold_en = 1'b0;
        rsp_q.delete();
        do_read(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, "to_rd");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/inert_intf_ctrl.md
Name: inert_intf_ctrl

Overview:
- Sequencing front-end for the 6-axis inertial sensor.
- Issues power-up configuration writes through an external 16-bit SPI transaction engine.
- On each sensor data-ready interrupt, reads pitch-rate and Z-accel byte pairs and presents them as signed 16-bit words with a one-cycle vld strobe.
- Feeds the downstream inertial integrator directly: ptch_rt, AZ and vld connect 1:1.

Parameters:
- INIT_WAIT_BITS, 16: width of the post-reset settle timer; configuration starts when the timer reaches all-ones.
- TIMEOUT_BITS, 10: width of the done-watchdog counter. Used only with INERT_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- INT  input  1  sensor data-ready, asynchronous to clk
- done  input  1  SPI engine: transaction complete, 1-cycle pulse
- rd_data  input  16  SPI engine: read data, valid when done=1; low byte significant
- wrt  output  1  SPI engine: start transaction, 1-cycle pulse
- cmd  output  16  SPI engine command word, held stable from wrt until done
- ptch_rt  output  16  signed pitch rate, {high byte, low byte}
- AZ  output  16  signed Z acceleration, {high byte, low byte}
- vld  output  1  1-cycle strobe: ptch_rt/AZ updated this cycle
- err  output  1  sticky SPI timeout flag (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge clk):
  - Outputs: wrt=0, vld=0, err=0, cmd=16'h0000, ptch_rt=0, AZ=0.
  - Internal state: settle timer=0, INT synchroniser=0, pending=0, state=SETTLE.
- INT handling:
  - Two-flop synchroniser, then rising-edge detect on the synchronised signal.
  - INT-to-edge latency is 3 clk.
- SETTLE: timer increments every cycle. When the timer is all-ones, go to CFG.
- CFG: four write transactions in order: 16'h0D02, 16'h1053, 16'h1150, 16'h1460.
  - Per transaction: wrt=1 for exactly one cycle with cmd loaded, then wait for done.
  - On done, launch the next wrt on the following cycle.
  - After the 4th done, go to IDLE.
  - INT edges during SETTLE/CFG are discarded; pending is not set.
- IDLE: on an INT edge, or if pending=1, clear pending and go to RD.
- RD: four read transactions in order, each capturing rd_data[7:0] on done:
  - 16'hA200 -> ptch_rt low byte
  - 16'hA300 -> ptch_rt high byte
  - 16'hAC00 -> AZ low byte
  - 16'hAD00 -> AZ high byte
- Output update:
  - Bytes are held in shadow registers.
  - ptch_rt and AZ are updated together in the cycle after the 4th done, with vld=1 in that same cycle.
  - Outputs never present mixed old/new halves.
- After the vld cycle, return to IDLE; the next read sequence can start the following cycle.
- INT edge during RD: sets pending. Multiple edges collapse into a single pending flag (no queue).
- Done handling:
  - done while not waiting for a transaction: ignored.
  - done in the same cycle as wrt: ignored; done is honoured from the cycle after wrt.
- No wrt is issued while a transaction is outstanding; at most one transaction is in flight.
- rst mid-transaction: immediate return to the reset state. A done arriving afterwards is ignored. Configuration reruns after the full settle period.
- Transaction latency: 1 cycle from state entry to wrt. Total RD time = 4 × (engine latency + 1) + 1 cycles to vld.

Optional Feature:
- Macro: INERT_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles while waiting for done and clears on each wrt.
  - When the count reaches all-ones: err is set (sticky until rst), the transaction is abandoned, and the block returns to IDLE with no vld.
  - A timeout during CFG restarts CFG from the first write instead of going to IDLE.
- Not defined: no watchdog logic is built, err is tied 0, and the block waits for done indefinitely.

Test Plan:
- Reset then settle: rst for 2 cycles -> no wrt for 2^INIT_WAIT_BITS-1 cycles; then wrt with cmd=0x0D02; engine model returns done after 5 cycles -> next wrt cmd=0x1053, and so on through 0x1460; then idle with no further wrt.
- Single read: after config, pulse INT -> wrt cmds A200, A300, AC00, AD00; rd_data low bytes 0x34, 0x12, 0x78, 0xF6 -> one vld cycle with ptch_rt=0x1234, AZ=0xF678; ptch_rt/AZ unchanged before vld.
- INT during read: second and third INT edges during the 2nd transaction -> exactly one extra read sequence after the first vld; two vld pulses total.
- INT during CFG: INT toggled during the 2nd config write -> no read sequence starts and no vld until a fresh INT after config.
- Reset mid-read: assert rst during the 3rd read's wait, then deliver done -> outputs stay 0, no vld, settle period restarts.
- With INERT_TIMEOUT_EN and TIMEOUT_BITS=4: withhold done after wrt cmd=0xA300 -> err=1 after 15 cycles, no vld, IDLE; the next INT completes a normal read and err stays 1.
